// File: rtl/prioritised_stream_splitter.sv
// rtl/prioritised_stream_splitter.sv - splits a tagged AXI-stream into hp/lp FIFO-backed output streams

// Circular register FIFO with first-word-fall-through read and explicit fill level.
module prioritised_stream_splitter_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   fill_level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage needs no reset: stale entries are never visible while fill_level is 0.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally at DEPTH (power of 2); fill tracks push/pop balance.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   fill_level <= fill_level + (AW+1)'(1);
        2'b01:   fill_level <= fill_level - (AW+1)'(1);
        default: fill_level <= fill_level;
      endcase
    end
  end

  assign pop_data = mem[rd_ptr];

endmodule

// Routes whole packets by their first-beat priority tag into hp or lp FIFOs.
module prioritised_stream_splitter #(
  parameter int INPUT_DATA_WIDTH = 32,
  parameter int FIFO_DEPTH       = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [INPUT_DATA_WIDTH-1:0]   data_in,
  input  logic                          data_in_valid,
  input  logic                          data_in_tlast,
  input  logic                          data_in_dest,
  output logic                          data_in_ready,
  output logic [INPUT_DATA_WIDTH-1:0]   data_out_hp,
  output logic                          data_out_hp_valid,
  output logic                          data_out_hp_tlast,
  input  logic                          data_out_hp_ready,
  output logic [INPUT_DATA_WIDTH-1:0]   data_out_lp,
  output logic                          data_out_lp_valid,
  output logic                          data_out_lp_tlast,
  input  logic                          data_out_lp_ready,
  output logic [$clog2(FIFO_DEPTH):0]   hp_fill_level,
  output logic [$clog2(FIFO_DEPTH):0]   lp_fill_level
);

  localparam int FW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [FW-1:0] FULL_LEVEL = FW'(FIFO_DEPTH);

  typedef enum logic {
    IDLE      = 1'b0,
    IN_PACKET = 1'b1
  } state_t;

  state_t state;
  logic   route;
  logic   sel_hp;
  logic   sel_full;
  logic   accept;
  logic   hp_push;
  logic   lp_push;
  logic   hp_pop;
  logic   lp_pop;
  logic [INPUT_DATA_WIDTH:0] hp_head;
  logic [INPUT_DATA_WIDTH:0] lp_head;

  // First beat routes on the live tag; later beats follow the latched route.
  always_comb begin
    sel_hp   = (state == IN_PACKET) ? route : data_in_dest;
    sel_full = sel_hp ? (hp_fill_level == FULL_LEVEL) : (lp_fill_level == FULL_LEVEL);
  end

  assign data_in_ready = reset & ~sel_full;
  assign accept        = data_in_valid & data_in_ready;
  assign hp_push       = accept & sel_hp;
  assign lp_push       = accept & ~sel_hp;
  assign hp_pop        = data_out_hp_valid & data_out_hp_ready;
  assign lp_pop        = data_out_lp_valid & data_out_lp_ready;

  // Packet framing FSM: latch the tag on a non-final first beat, release on tlast.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      route <= 1'b0;
    end else if (accept) begin
      case (state)
        IDLE: begin
          if (!data_in_tlast) begin
            state <= IN_PACKET;
            route <= data_in_dest;
          end
        end
        IN_PACKET: begin
          if (data_in_tlast) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  prioritised_stream_splitter_fifo #(
    .WIDTH (INPUT_DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_hp_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (hp_push),
    .push_data  ({data_in_tlast, data_in}),
    .pop        (hp_pop),
    .pop_data   (hp_head),
    .fill_level (hp_fill_level)
  );

  prioritised_stream_splitter_fifo #(
    .WIDTH (INPUT_DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_lp_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (lp_push),
    .push_data  ({data_in_tlast, data_in}),
    .pop        (lp_pop),
    .pop_data   (lp_head),
    .fill_level (lp_fill_level)
  );

  // Outputs are forced quiet while reset is held, even before the first reset edge.
  always_comb begin
    data_out_hp_valid = reset & (hp_fill_level != '0);
    data_out_lp_valid = reset & (lp_fill_level != '0);
    data_out_hp       = reset ? hp_head[INPUT_DATA_WIDTH-1:0] : '0;
    data_out_lp       = reset ? lp_head[INPUT_DATA_WIDTH-1:0] : '0;
    data_out_hp_tlast = reset & hp_head[INPUT_DATA_WIDTH];
    data_out_lp_tlast = reset & lp_head[INPUT_DATA_WIDTH];
  end

endmodule

// File: doc/prioritised_stream_splitter.md
Name: prioritised_stream_splitter

Overview:
Receive-side counterpart of the priority merger. Takes one AXI-stream input whose packets carry a 1-bit priority tag and routes each whole packet into one of two internal FIFOs, high priority or low priority. Each FIFO drains through its own independent AXI-stream output. Sits at the far end of a link that carries merged hp/lp traffic and restores the two separate channels.

Parameters:
INPUT_DATA_WIDTH, 32, width of the data bus on input and both outputs.
FIFO_DEPTH, 16, entries per internal FIFO; must be a power of 2 and >= 2.

Ports:
clock  in  1  system clock.
reset  in  1  synchronous, active-low reset.
data_in  in  INPUT_DATA_WIDTH  input beat data.
data_in_valid  in  1  input beat valid.
data_in_tlast  in  1  last beat of input packet.
data_in_dest  in  1  priority tag (1 = hp, 0 = lp); sampled on the first beat of a packet only.
data_in_ready  out  1  input accept.
data_out_hp  out  INPUT_DATA_WIDTH  hp output data.
data_out_hp_valid  out  1  hp output valid.
data_out_hp_tlast  out  1  hp output last.
data_out_hp_ready  in  1  hp output accept.
data_out_lp  out  INPUT_DATA_WIDTH  lp output data.
data_out_lp_valid  out  1  lp output valid.
data_out_lp_tlast  out  1  lp output last.
data_out_lp_ready  in  1  lp output accept.
hp_fill_level  out  clog2(FIFO_DEPTH)+1  hp FIFO occupancy.
lp_fill_level  out  clog2(FIFO_DEPTH)+1  lp FIFO occupancy.

Behaviour:
- Transfer on any interface occurs when valid & ready are both high at a rising clock edge.
- Reset (reset==0 at an edge):
  - pointers and fill levels go to 0; in_packet=0; route=0.
  - While reset is low: data_in_ready=0, both out_valid=0, out_tlast=0, out data=0.
  - Reset mid-packet discards all stored and partial data. There is no recovery of a partial packet.
- Routing FSM, two states:
  - IDLE (in_packet=0): the selected FIFO is given by data_in_dest.
  - IN_PACKET (in_packet=1): the selected FIFO is given by latched route.
  - IDLE -> IN_PACKET on an accepted beat with tlast=0; route <= data_in_dest.
  - IN_PACKET -> IDLE on an accepted beat with tlast=1.
  - A single-beat packet (tlast=1 on the first beat) stays in IDLE.
  - data_in_dest is ignored while IN_PACKET.
- data_in_ready = reset & (selected FIFO fill_level != FIFO_DEPTH). It is combinational from state and data_in_dest.
  - A full hp FIFO must not block lp packets, and vice versa.
- Each FIFO:
  - circular register buffer of {tlast, data}, width INPUT_DATA_WIDTH+1;
  - write and read pointers are clog2(FIFO_DEPTH) bits and wrap naturally from FIFO_DEPTH-1 to 0;
  - fill level is clog2(FIFO_DEPTH)+1 bits.
  - Push on an accepted input beat routed to it; pop on an accepted output beat.
  - Push and pop in the same cycle: fill unchanged, both pointers advance.
  - Push only: +1. Pop only: -1.
- Outputs are first-word-fall-through:
  - out_valid = (fill_level != 0);
  - out data and tlast = entry at the read pointer, combinational read.
- Latency: a beat accepted at edge N is valid on its output after edge N, giving a 1-cycle input-to-output latency.
- Ordering:
  - beats within each FIFO stay strictly in order;
  - there is no ordering guarantee between hp and lp.
- Full/empty:
  - a full FIFO stalls input only while it is the selected FIFO;
  - an empty FIFO holds out_valid=0, and the out_ready level is ignored.
- Output valid/data must stay stable while valid=1 and ready=0.

Test Plan:
1. Reset, then a 3-beat packet (dest=1, data 0xA1,0xA2,0xA3 with tlast on 0xA3), hp_ready=1 -> the three beats appear on hp in order, one cycle after each input beat, tlast on 0xA3; lp_valid stays 0; fill levels return to 0.
2. A 4-beat packet where dest=0 on beat 1 and dest toggles to 1 on beats 2-4 -> all 4 beats appear on lp; hp receives nothing.
3. hp_ready=0, 16 single-beat hp packets -> hp_fill_level=16 and data_in_ready=0 for dest=1. Then present dest=0 -> data_in_ready=1, the lp beat is accepted and appears on lp.
4. hp full at 16 with simultaneous push and pop (hp_ready=1 after a stall) -> fill returns to 15 then tracks; data order 0..N is preserved across pointer wrap after 40 beats.
5. Reset low on the second beat of a 5-beat hp packet -> outputs invalid, fills 0, in_packet=0. The next packet's dest is honoured freshly.
6. Random valid/ready on all three ports, 1000 beats, random dest -> scoreboard per-channel order matches, and no beat is lost or duplicated.
